// File: rtl/uart_async_rx_if.sv
// Receive-side bundle of the 8N1 UART receiver: serial line in, byte and status out.
// The slave modport is the receiver; the master modport is whoever drives the line.
interface uart_async_rx_if;
  logic       RxD;
  logic       RxD_data_ready;
  logic       RxD_waiting_data;
  logic [7:0] RxD_data;

  modport master (
    output RxD,
    input  RxD_data_ready,
    input  RxD_waiting_data,
    input  RxD_data
  );

  modport slave (
    input  RxD,
    output RxD_data_ready,
    output RxD_waiting_data,
    output RxD_data
  );
endinterface

// File: rtl/uart_async_rx.sv
// Oversampling 8N1 UART receiver: synchroniser, 3-tap majority filter, tick-driven
// frame FSM and a one-byte output register with a single-cycle ready strobe.
module uart_async_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_async_rx_if.slave  rx
);

  localparam int TICK_RATE = BAUD * OVERSAMPLE;
  localparam int DIV_RAW   = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
  localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W     = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Free-running oversample tick; deliberately never realigned to frames.
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;

  assign w_tick = (r_div_cnt == DIV_LAST);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Synchroniser and filter reset to the idle-high level so reset never looks like a start.
  logic [1:0] r_sync;
  logic [1:0] r_hist;
  logic       r_rx_f;
  logic       w_rx_s;
  logic       w_maj;

  assign w_rx_s = r_sync[1];
  assign w_maj  = (r_hist[0] & r_hist[1]) | (r_hist[0] & w_rx_s) | (r_hist[1] & w_rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_hist <= 2'b11;
      r_rx_f <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], rx.RxD};
      if (w_tick) begin
        r_hist <= {r_hist[0], w_rx_s};
        r_rx_f <= w_maj;
      end
    end
  end

  state_t           r_state,   w_state;
  logic [CNT_W-1:0] r_cnt,     w_cnt;
  logic [2:0]       r_bit_idx, w_bit_idx;
  logic [7:0]       r_shift,   w_shift;
  logic [7:0]       r_data,    w_data;
  logic             r_ready,   w_ready;
  logic             r_waiting, w_waiting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_ready   <= 1'b0;
      r_waiting <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_bit_idx <= w_bit_idx;
      r_shift   <= w_shift;
      r_data    <= w_data;
      r_ready   <= w_ready;
      r_waiting <= w_waiting;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_bit_idx = r_bit_idx;
    w_shift   = r_shift;
    w_data    = r_data;
    w_ready   = 1'b0;
    w_waiting = r_waiting;

    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_rx_f) begin
            w_cnt   = '0;
            w_state = S_START;
          end
        end

        // Re-check at mid start bit; pulses shorter than half a bit fall back to idle.
        S_START: begin
          if (r_cnt == CNT_HALF) begin
            if (!r_rx_f) begin
              w_state   = S_DATA;
              w_cnt     = '0;
              w_bit_idx = '0;
              w_waiting = 1'b1;
            end else begin
              w_state = S_IDLE;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt   = '0;
            w_shift = {r_rx_f, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              w_state = S_STOP;
            end else begin
              w_bit_idx = r_bit_idx + 1'b1;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end

        // A low stop bit is a framing error: the byte is dropped and the line must idle first.
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt     = '0;
            w_waiting = 1'b0;
            if (r_rx_f) begin
              w_data  = r_shift;
              w_ready = 1'b1;
              w_state = S_IDLE;
            end else begin
              w_state = S_BREAK;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          if (r_rx_f) begin
            w_state = S_IDLE;
          end
        end

        default: w_state = S_IDLE;
      endcase
    end
  end

  assign rx.RxD_data_ready   = r_ready;
  assign rx.RxD_waiting_data = r_waiting;
  assign rx.RxD_data         = r_data;

endmodule

// File: tb/tb_uart_async_rx.sv
// Directed plus randomized bench for uart_async_rx at DIV=1 (8 clocks per bit); received
// bytes are compared against a frame-level model of what the line carried.
module tb_uart_async_rx;

  localparam int CLK_FREQ = 8;
  localparam int BAUD     = 1;
  localparam int OS       = 8;
  localparam int BIT_CLKS = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_async_rx_if u_if ();

  uart_async_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (u_if)
  );

  // Monitor: owned exclusively by these blocks; the stimulus only reads them.
  int         cyc            = 0;
  int         pulses         = 0;
  int         wait_cyc       = 0;
  int         run            = 0;
  int         max_run        = 0;
  int         last_pulse_cyc = 0;
  logic [7:0] rx_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.RxD_data_ready === 1'b1) begin
      pulses         <= pulses + 1;
      last_pulse_cyc <= cyc;
      rx_q.push_back(u_if.RxD_data);
      run            <= run + 1;
      if (run + 1 > max_run) max_run <= run + 1;
    end else begin
      run <= 0;
    end
    if (u_if.RxD_waiting_data === 1'b1) wait_cyc <= wait_cyc + 1;
  end

  // Frame-level reference: a frame with a high stop bit delivers its byte, any other does not.
  logic [7:0] exp_q [$];
  logic [7:0] model_data = 8'h00;
  int         rd_idx     = 0;
  int         n_checks   = 0;
  int         n_pass     = 0;
  int         t_start    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
  endtask

  task automatic drive(input logic v, input int n);
    u_if.RxD = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    if (n > 0) drive(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low);
    t_start = cyc;
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(b[i], BIT_CLKS);
    drive(stop_bit, BIT_CLKS);
    if (!stop_bit && extra_low > 0) drive(1'b0, extra_low);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back(b);
      model_data = b;
    end
  endtask

  task automatic drain(input string tag);
    check({tag, " count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    while (rd_idx < exp_q.size() && rd_idx < rx_q.size()) begin
      check({tag, " byte"}, 32'(rx_q[rd_idx]), 32'(exp_q[rd_idx]));
      rd_idx++;
    end
    rd_idx = exp_q.size();
    check({tag, " hold"}, 32'(u_if.RxD_data), 32'(model_data));
  endtask

  initial begin
    logic [7:0] b;
    logic       good;
    int         w0;

    rst      = 1'b1;
    u_if.RxD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset data",    32'(u_if.RxD_data),         32'h00);
    check("reset ready",   32'(u_if.RxD_data_ready),   32'h0);
    check("reset waiting", 32'(u_if.RxD_waiting_data), 32'h0);
    rst = 1'b0;
    idle(20 * BIT_CLKS);
    check("quiet pulses",  32'(pulses),   32'h0);
    check("quiet waiting", 32'(wait_cyc), 32'h0);

    // Single bytes: ready about 9.5 bits after the start edge, waiting about 9 bits.
    w0 = wait_cyc;
    send_frame(8'hFF, 1'b1, 0);
    model_frame(8'hFF, 1'b1);
    idle(16);
    drain("single FF");
    check_range("latency FF", last_pulse_cyc - t_start, 72, 84);
    check_range("waiting FF", wait_cyc - w0, 64, 80);

    w0 = wait_cyc;
    send_frame(8'hA5, 1'b1, 0);
    model_frame(8'hA5, 1'b1);
    idle(16);
    drain("single A5");
    check_range("latency A5", last_pulse_cyc - t_start, 72, 84);
    check_range("waiting A5", wait_cyc - w0, 64, 80);

    // Back-to-back frames with a one-bit stop and no idle gap.
    send_frame(8'h00, 1'b1, 0); model_frame(8'h00, 1'b1);
    send_frame(8'h55, 1'b1, 0); model_frame(8'h55, 1'b1);
    send_frame(8'h80, 1'b1, 0); model_frame(8'h80, 1'b1);
    idle(16);
    drain("b2b");

    // Framing error followed by a good frame.
    send_frame(8'h3C, 1'b0, 2 * BIT_CLKS);
    model_frame(8'h3C, 1'b0);
    idle(4 * BIT_CLKS);
    drain("framing");
    send_frame(8'h12, 1'b1, 0);
    model_frame(8'h12, 1'b1);
    idle(16);
    drain("after framing");

    // Filter glitch and false start must leave the receiver idle.
    w0 = wait_cyc;
    drive(1'b0, 1);
    idle(20);
    drive(1'b0, 3);
    idle(40);
    check("glitch waiting", 32'(wait_cyc - w0), 32'h0);
    drain("glitch");
    send_frame(8'h7E, 1'b1, 0);
    model_frame(8'h7E, 1'b1);
    idle(16);
    drain("after glitch");

    // Random bytes with occasional framing errors and random inter-frame gaps.
    for (int i = 0; i < 24; i++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send_frame(b, good, good ? 0 : int'($urandom_range(0, 16)));
      model_frame(b, good);
      idle(good ? int'($urandom_range(0, 12)) : 16 + int'($urandom_range(0, 8)));
    end
    idle(16);
    drain("random");

    // Reset during bit 4 of 0xC3 aborts the frame without a ready pulse.
    b = 8'hC3;
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(b[i], BIT_CLKS);
    u_if.RxD = b[4];
    repeat (3) @(posedge clk);
    #2;
    check("midframe waiting", 32'(u_if.RxD_waiting_data), 32'h1);
    rst = 1'b1;
    #1;
    check("abort data",    32'(u_if.RxD_data),         32'h00);
    check("abort waiting", 32'(u_if.RxD_waiting_data), 32'h0);
    check("abort ready",   32'(u_if.RxD_data_ready),   32'h0);
    u_if.RxD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_data = 8'h00;
    idle(3 * BIT_CLKS);
    drain("post reset");
    send_frame(8'h81, 1'b1, 0);
    model_frame(8'h81, 1'b1);
    idle(16);
    drain("after reset");

    check("ready width", 32'(max_run), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
